// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter: round-robin sharing of one DMI port between two requesters, one outstanding transaction.
module dmi_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic [40:0] m0_req_i,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  output logic [33:0] m0_resp_o,
  output logic        m0_resp_valid_o,
  input  logic        m0_resp_ready_i,
  input  logic        m0_clear_i,
  input  logic [40:0] m1_req_i,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  output logic [33:0] m1_resp_o,
  output logic        m1_resp_valid_o,
  input  logic        m1_resp_ready_i,
  input  logic        m1_clear_i,
  output logic [40:0] s_req_o,
  output logic        s_req_valid_o,
  input  logic        s_req_ready_i,
  input  logic [33:0] s_resp_i,
  input  logic        s_resp_valid_i,
  output logic        s_resp_ready_o,
  output logic        owner_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        stray_o
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0] DTM_ERR = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_e;
  state_e state_q, state_d;
  logic [40:0] s_req_q, s_req_d;
  logic [33:0] resp0_q, resp0_d, resp1_q, resp1_d, rd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic owner_q, owner_d, timeout_q, timeout_d, stray_q, stray_d;
  logic e0, e1, gnt, own_clr, own_rdy, tmo, idle;
  assign e0 = m0_req_valid_i & ~m0_clear_i;
  assign e1 = m1_req_valid_i & ~m1_clear_i;
  // with both eligible the grant goes to whoever did not win last time
  assign gnt = (e0 & e1) ? ~owner_q : e1;
  assign own_clr = owner_q ? m1_clear_i : m0_clear_i;
  assign own_rdy = owner_q ? m1_resp_ready_i : m0_resp_ready_i;
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign rd = s_resp_valid_i ? s_resp_i : {32'h0, DTM_ERR};
  assign idle = state_q == IDLE;
  always_comb begin
    state_d = state_q;
    s_req_d = s_req_q;
    resp0_d = resp0_q;
    resp1_d = resp1_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    timeout_d = 1'b0;
    stray_d = s_resp_valid_i & (state_q != WAIT_RESP);
    case (state_q)
      IDLE: if (e0 | e1) begin
        state_d = REQ;
        owner_d = gnt;
        s_req_d = gnt ? m1_req_i : m0_req_i;
      end
      REQ: begin
        state_d = own_clr ? IDLE : s_req_ready_i ? WAIT_RESP : REQ;
        cnt_d = '0;
      end
      WAIT_RESP: if (own_clr) begin
        state_d = IDLE;
        stray_d = s_resp_valid_i;
      end else if (s_resp_valid_i | tmo) begin
        state_d = RESP;
        resp0_d = owner_q ? resp0_q : rd;
        resp1_d = owner_q ? rd : resp1_q;
        timeout_d = ~s_resp_valid_i;
      end else cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      RESP: state_d = (own_clr | own_rdy) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_req_q <= '0;
      resp0_q <= '0;
      resp1_q <= '0;
      owner_q <= 1'b1;
      cnt_q <= '0;
      timeout_q <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_req_q <= s_req_d;
      resp0_q <= resp0_d;
      resp1_q <= resp1_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
      stray_q <= stray_d;
    end
  end
  assign m0_req_ready_o = rst_ni & idle & e0 & ~gnt;
  assign m1_req_ready_o = rst_ni & idle & e1 & gnt;
  assign m0_resp_o = resp0_q;
  assign m1_resp_o = resp1_q;
  assign m0_resp_valid_o = (state_q == RESP) & ~owner_q;
  assign m1_resp_valid_o = (state_q == RESP) & owner_q;
  assign s_req_o = s_req_q;
  assign s_req_valid_o = state_q == REQ;
  assign s_resp_ready_o = 1'b1;
  assign owner_o = owner_q;
  assign busy_o = ~idle;
  assign timeout_o = timeout_q;
  assign stray_o = stray_q;
endmodule

// File: tb/tb_dmi_req_arbiter.sv
// tb_dmi_req_arbiter: scenario tasks with a request/response scoreboard for dmi_req_arbiter.
module tb_dmi_req_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [40:0] m0_req_i, m1_req_i, s_req_o;
  logic [33:0] m0_resp_o, m1_resp_o, s_resp_i;
  logic m0_req_valid_i, m0_req_ready_o, m0_resp_valid_o, m0_resp_ready_i, m0_clear_i;
  logic m1_req_valid_i, m1_req_ready_o, m1_resp_valid_o, m1_resp_ready_i, m1_clear_i;
  logic s_req_valid_o, s_req_ready_i, s_resp_valid_i, s_resp_ready_o;
  logic owner_o, busy_o, timeout_o, stray_o;
  int errors = 0;
  int checks = 0;
  logic [40:0] req_q[$];
  logic [33:0] rsp0_q[$], rsp1_q[$];
  int ord_q[$];
  logic [40:0] er;
  logic [33:0] ep;

  always #5 clk = ~clk;

  dmi_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_resp_o(m0_resp_o), .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready_i),
    .m0_clear_i(m0_clear_i),
    .m1_req_i(m1_req_i), .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_resp_o(m1_resp_o), .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready_i),
    .m1_clear_i(m1_clear_i),
    .s_req_o(s_req_o), .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
    .s_resp_i(s_resp_i), .s_resp_valid_i(s_resp_valid_i), .s_resp_ready_o(s_resp_ready_o),
    .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o), .stray_o(stray_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_i = '0; m0_req_valid_i = 0; m0_resp_ready_i = 0; m0_clear_i = 0;
    m1_req_i = '0; m1_req_valid_i = 0; m1_resp_ready_i = 0; m1_clear_i = 0;
    s_req_ready_i = 0; s_resp_i = '0; s_resp_valid_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_req_valid_o, busy_o, owner_o, m0_resp_valid_o, m1_resp_valid_o, timeout_o, stray_o,
         s_resp_ready_o, m0_req_ready_o, m1_req_ready_o} !== 10'b0010000100) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0010000100", {s_req_valid_o, busy_o, owner_o,
               m0_resp_valid_o, m1_resp_valid_o, timeout_o, stray_o, s_resp_ready_o,
               m0_req_ready_o, m1_req_ready_o});
    end
    checks++;
    if ({s_req_o, m0_resp_o, m1_resp_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", s_req_o, m0_resp_o, m1_resp_o);
    end
    rst_ni = 1;
    step();
  endtask

  task automatic test_basic_write();
    m0_req_i = {7'h10, 2'd2, 32'h07FFFFC1};
    m0_req_valid_i = 1;
    req_q.push_back(m0_req_i);
    #1;
    checks++;
    if ({m1_req_ready_o, m0_req_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL basic_ready got=%b exp=01", {m1_req_ready_o, m0_req_ready_o});
    end
    step();
    m0_req_valid_i = 0;
    er = req_q.pop_front();
    checks++;
    if (s_req_valid_o !== 1'b1 || s_req_o !== er || owner_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_sreq got=%b/%h/%b exp=1/%h/0", s_req_valid_o, s_req_o, owner_o, er);
    end
    s_req_ready_i = 1;
    step();
    s_req_ready_i = 0;
    s_resp_i = {32'h0, 2'd0};
    s_resp_valid_i = 1;
    rsp0_q.push_back(s_resp_i);
    step();
    s_resp_valid_i = 0;
    ep = rsp0_q.pop_front();
    checks++;
    if ({m1_resp_valid_o, m0_resp_valid_o} !== 2'b01 || m0_resp_o !== ep) begin
      errors++;
      $display("FAIL basic_resp got=%b/%h exp=01/%h", {m1_resp_valid_o, m0_resp_valid_o}, m0_resp_o, ep);
    end
    m0_resp_ready_i = 1;
    step();
    m0_resp_ready_i = 0;
    checks++;
    if (busy_o !== 1'b0 || m0_resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got busy=%b rv=%b exp=0/0", busy_o, m0_resp_valid_o);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp;
    logic [40:0] a, b;
    do_reset();
    a = {7'h20, 2'd1, 32'hAAAA0000};
    b = {7'h21, 2'd1, 32'hBBBB0000};
    m0_req_i = a; m1_req_i = b;
    m0_req_valid_i = 1; m1_req_valid_i = 1;
    m0_resp_ready_i = 1; m1_resp_ready_i = 1;
    s_req_ready_i = 1;
    ord_q = '{0, 1, 0, 1};
    #1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (!(m0_req_ready_o | m1_req_ready_o) && n < 10) begin
        step();
        n++;
      end
      exp = ord_q.pop_front();
      checks++;
      if ({m1_req_ready_o, m0_req_ready_o} !== (exp == 1 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant%0d got=%b exp_req=%0d", t, {m1_req_ready_o, m0_req_ready_o}, exp);
      end
      req_q.push_back(exp == 1 ? b : a);
      step();
      er = req_q.pop_front();
      checks++;
      if (s_req_o !== er || s_req_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL rr_sreq%0d got=%h exp=%h", t, s_req_o, er);
      end
      step();
      s_resp_i = {32'(t + 32'h100), 2'd0};
      s_resp_valid_i = 1;
      if (exp == 1) rsp1_q.push_back(s_resp_i);
      else rsp0_q.push_back(s_resp_i);
      step();
      s_resp_valid_i = 0;
      ep = (exp == 1) ? rsp1_q.pop_front() : rsp0_q.pop_front();
      checks++;
      if ({m1_resp_valid_o, m0_resp_valid_o} !== (exp == 1 ? 2'b10 : 2'b01) ||
          (exp == 1 ? m1_resp_o : m0_resp_o) !== ep) begin
        errors++;
        $display("FAIL rr_resp%0d got=%b/%h/%h exp_req=%0d data=%h", t,
                 {m1_resp_valid_o, m0_resp_valid_o}, m0_resp_o, m1_resp_o, exp, ep);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_read_m1();
    m1_req_i = {7'h11, 2'd1, 32'h0};
    m1_req_valid_i = 1;
    req_q.push_back(m1_req_i);
    #1;
    checks++;
    if ({m1_req_ready_o, m0_req_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL read_ready got=%b exp=10", {m1_req_ready_o, m0_req_ready_o});
    end
    step();
    m1_req_valid_i = 0;
    er = req_q.pop_front();
    checks++;
    if (s_req_o !== er) begin
      errors++;
      $display("FAIL read_sreq got=%h exp=%h", s_req_o, er);
    end
    s_req_ready_i = 1;
    step();
    s_req_ready_i = 0;
    s_resp_i = {32'hCAFEBABE, 2'd0};
    s_resp_valid_i = 1;
    rsp1_q.push_back(s_resp_i);
    step();
    s_resp_valid_i = 0;
    ep = rsp1_q.pop_front();
    checks++;
    if ({m1_resp_valid_o, m0_resp_valid_o} !== 2'b10 || m1_resp_o !== ep) begin
      errors++;
      $display("FAIL read_resp got=%b/%h exp=10/%h", {m1_resp_valid_o, m0_resp_valid_o}, m1_resp_o, ep);
    end
    m1_resp_ready_i = 1;
    step();
    m1_resp_ready_i = 0;
  endtask

  task automatic test_timeout();
    m1_req_i = {7'h12, 2'd1, 32'h0};
    m1_req_valid_i = 1;
    step();
    m1_req_valid_i = 0;
    s_req_ready_i = 1;
    step();
    s_req_ready_i = 0;
    rsp1_q.push_back({32'h0, 2'd2});
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if (m1_resp_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL tmo_early%0d got rv=%b to=%b exp=0/0", i, m1_resp_valid_o, timeout_o);
      end
    end
    step();
    ep = rsp1_q.pop_front();
    checks++;
    if (m1_resp_valid_o !== 1'b1 || timeout_o !== 1'b1 || m1_resp_o !== ep) begin
      errors++;
      $display("FAIL tmo_fire got rv=%b to=%b d=%h exp=1/1/%h", m1_resp_valid_o, timeout_o, m1_resp_o, ep);
    end
    step();
    checks++;
    if (timeout_o !== 1'b0 || m1_resp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_pulse got to=%b rv=%b exp=0/1", timeout_o, m1_resp_valid_o);
    end
    m1_resp_ready_i = 1;
    step();
    m1_resp_ready_i = 0;
    s_resp_i = {32'h12345678, 2'd0};
    s_resp_valid_i = 1;
    step();
    s_resp_valid_i = 0;
    checks++;
    if (stray_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_stray got stray=%b busy=%b exp=1/0", stray_o, busy_o);
    end
    step();
    checks++;
    if (stray_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_stray_clr got=%b exp=0", stray_o);
    end
  endtask

  task automatic test_clear();
    m0_req_i = {7'h13, 2'd2, 32'h11112222};
    m0_req_valid_i = 1;
    req_q.push_back(m0_req_i);
    step();
    m0_req_valid_i = 0;
    er = req_q.pop_front();
    checks++;
    if (s_req_o !== er || owner_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_sreq0 got=%h/%b exp=%h/0", s_req_o, owner_o, er);
    end
    s_req_ready_i = 1;
    step();
    s_req_ready_i = 0;
    m0_clear_i = 1;
    m1_req_i = {7'h14, 2'd1, 32'h0};
    m1_req_valid_i = 1;
    req_q.push_back(m1_req_i);
    step();
    checks++;
    if (busy_o !== 1'b0 || m1_req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL clr_idle got busy=%b rdy1=%b exp=0/1", busy_o, m1_req_ready_o);
    end
    m0_clear_i = 0;
    step();
    m1_req_valid_i = 0;
    er = req_q.pop_front();
    checks++;
    if (owner_o !== 1'b1 || s_req_o !== er) begin
      errors++;
      $display("FAIL clr_regrant got=%b/%h exp=1/%h", owner_o, s_req_o, er);
    end
    s_resp_i = {32'hDEADBEEF, 2'd0};
    s_resp_valid_i = 1;
    step();
    s_resp_valid_i = 0;
    checks++;
    if (stray_o !== 1'b1 || m1_resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_late got stray=%b rv1=%b exp=1/0", stray_o, m1_resp_valid_o);
    end
    s_req_ready_i = 1;
    step();
    s_req_ready_i = 0;
    s_resp_i = {32'h600DF00D, 2'd0};
    s_resp_valid_i = 1;
    rsp1_q.push_back(s_resp_i);
    step();
    s_resp_valid_i = 0;
    ep = rsp1_q.pop_front();
    checks++;
    if (m1_resp_valid_o !== 1'b1 || m1_resp_o !== ep) begin
      errors++;
      $display("FAIL clr_resp1 got=%b/%h exp=1/%h", m1_resp_valid_o, m1_resp_o, ep);
    end
    m1_resp_ready_i = 1;
    step();
    m1_resp_ready_i = 0;
  endtask

  task automatic test_stall_reset();
    m0_req_i = {7'h15, 2'd2, 32'h5A5A5A5A};
    m0_req_valid_i = 1;
    req_q.push_back(m0_req_i);
    step();
    m0_req_i = '1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (s_req_valid_o !== 1'b1 || s_req_o !== req_q[0]) begin
        errors++;
        $display("FAIL stall%0d got=%b/%h exp=1/%h", i, s_req_valid_o, s_req_o, req_q[0]);
      end
      step();
    end
    rst_ni = 0;
    #1;
    checks++;
    if ({s_req_valid_o, busy_o, owner_o, m0_resp_valid_o, m1_resp_valid_o, timeout_o, stray_o,
         s_resp_ready_o, m0_req_ready_o, m1_req_ready_o} !== 10'b0010000100) begin
      errors++;
      $display("FAIL midreset_flags got=%b exp=0010000100", {s_req_valid_o, busy_o, owner_o,
               m0_resp_valid_o, m1_resp_valid_o, timeout_o, stray_o, s_resp_ready_o,
               m0_req_ready_o, m1_req_ready_o});
    end
    checks++;
    if ({s_req_o, m0_resp_o, m1_resp_o} !== '0) begin
      errors++;
      $display("FAIL midreset_data got=%h/%h/%h exp=0", s_req_o, m0_resp_o, m1_resp_o);
    end
    req_q.delete();
    idle_inputs();
    step();
    rst_ni = 1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_basic_write();
    test_round_robin();
    test_read_m1();
    test_timeout();
    test_clear();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
